counter_rr_sched: RTL and testbench

- Round-robin scheduler/controller for a pair of SIZE-bit up-counters that share one incrementer.
- Two requesters compete for the incrementer; at most one counter advances per cycle.
- A run FSM bounds the activity: start, optional stop, and completion when a counter reaches a programmable terminal count.
- The combined count q = val1 + val2 is exported, matching the existing dual-counter sum output.

---
 rtl/counter_rr_sched.sv | 94 +++++++++
 tb/tb_counter_rr_sched.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/counter_rr_sched.sv
// Round-robin scheduler for two SIZE-bit up-counters sharing one incrementer, with an IDLE/RUN/DONE run FSM.
// Optional build macro COUNTER_SATURATE_EN: counters saturate at 2^SIZE-1 instead of wrapping.
//
// state | meaning
// IDLE  | waiting for start; counters held
// RUN   | grants issued, granted counter advances
// DONE  | terminal count reached; counters held until start
module counter_rr_sched #(
  parameter int SIZE = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            stop,
  input  logic [1:0]      req,
  input  logic [SIZE-1:0] tc,
  output logic [1:0]      gnt,
  output logic [SIZE-1:0] val1,
  output logic [SIZE-1:0] val2,
  output logic [SIZE-1:0] q,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic            rr_ptr;
  logic [SIZE-1:0] inc_src;
  logic [SIZE-1:0] inc_res;
  logic            hit;

  // rr_ptr = 0 favours requester 1, 1 favours requester 2
  always_comb begin
    gnt = 2'b00;
    if (state == RUN && !start && !stop) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = rr_ptr ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    inc_src = gnt[1] ? val2 : val1;
`ifdef COUNTER_SATURATE_EN
    inc_res = (&inc_src) ? inc_src : inc_src + SIZE'(1);
`else
    inc_res = inc_src + SIZE'(1);
`endif
    hit = (|gnt) && (inc_res == tc);
  end

  assign q = val1 + val2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      val1   <= '0;
      val2   <= '0;
      rr_ptr <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else if (start) begin
      state <= RUN;
      val1  <= '0;
      val2  <= '0;
      busy  <= 1'b1;
      done  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (|gnt) begin
            if (gnt[0]) val1 <= inc_res;
            else        val2 <= inc_res;
            rr_ptr <= gnt[0];
            if (hit) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_rr_sched.sv
// Directed self-checking bench for counter_rr_sched (SIZE = 4 so the wrap case is short).
// Expectations follow COUNTER_SATURATE_EN when the bench is built with it.
module tb_counter_rr_sched;
  localparam int SIZE = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            stop;
  logic [1:0]      req;
  logic [SIZE-1:0] tc;
  logic [1:0]      gnt;
  logic [SIZE-1:0] val1;
  logic [SIZE-1:0] val2;
  logic [SIZE-1:0] q;
  logic            busy;
  logic            done;

  int tests = 0;
  int fails = 0;

  counter_rr_sched #(.SIZE(SIZE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .req(req), .tc(tc),
    .gnt(gnt), .val1(val1), .val2(val2), .q(q), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [1:0] r, input logic [SIZE-1:0] t);
    req = r; tc = t; start = 1'b1; stop = 1'b0;
    step();
    start = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; req = 2'b11; tc = 4'd10;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL reset_gnt got %b want 00", gnt); end
    tests++; if (val1 !== 4'd0 || val2 !== 4'd0) begin fails++; $display("FAIL reset_vals got %0d/%0d want 0/0", val1, val2); end
    tests++; if (q !== 4'd0) begin fails++; $display("FAIL reset_q got %0d want 0", q); end
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
    rst_n = 1'b1;
    step();
    tests++; if (gnt !== 2'b00 || busy !== 1'b0) begin fails++; $display("FAIL idle_no_start got gnt=%b busy=%b want 00/0", gnt, busy); end
  endtask

  task automatic test_fair();
    logic [1:0] exp_g;
    pulse_start(2'b11, 4'd10);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL fair_busy got %b want 1", busy); end
    for (int i = 0; i < 6; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      tests++; if (gnt !== exp_g) begin fails++; $display("FAIL fair_gnt[%0d] got %b want %b", i, gnt, exp_g); end
      step();
    end
    req = 2'b00;
    #1;
    tests++; if (val1 !== 4'd3 || val2 !== 4'd3) begin fails++; $display("FAIL fair_vals got %0d/%0d want 3/3", val1, val2); end
    tests++; if (q !== 4'd6) begin fails++; $display("FAIL fair_q got %0d want 6", q); end
    tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL fair_noreq_gnt got %b want 00", gnt); end
  endtask

  task automatic test_restart();
    pulse_start(2'b11, 4'd10);
    tests++; if (gnt !== 2'b01) begin fails++; $display("FAIL restart_first_gnt got %b want 01", gnt); end
    step();
    start = 1'b1;
    #1;
    tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL restart_gnt_during_start got %b want 00", gnt); end
    step();
    start = 1'b0;
    #1;
    tests++; if (val1 !== 4'd0 || val2 !== 4'd0 || busy !== 1'b1) begin fails++; $display("FAIL restart_clear got %0d/%0d busy=%b want 0/0/1", val1, val2, busy); end
    tests++; if (gnt !== 2'b10) begin fails++; $display("FAIL restart_ptr_kept got %b want 10", gnt); end
    step();
    req = 2'b00;
    #1;
    tests++; if (val2 !== 4'd1 || val1 !== 4'd0) begin fails++; $display("FAIL restart_inc got %0d/%0d want 0/1", val1, val2); end
  endtask

  task automatic test_single();
    pulse_start(2'b10, 4'd4);
    for (int i = 0; i < 4; i++) begin
      tests++; if (gnt !== 2'b10) begin fails++; $display("FAIL single_gnt[%0d] got %b want 10", i, gnt); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL single_early_done[%0d] got %b want 0", i, done); end
      step();
    end
    tests++; if (done !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL single_done got done=%b busy=%b want 1/0", done, busy); end
    tests++; if (val2 !== 4'd4 || val1 !== 4'd0) begin fails++; $display("FAIL single_vals got %0d/%0d want 0/4", val1, val2); end
    tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL single_gnt_after_done got %b want 00", gnt); end
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
    tests++; if (done !== 1'b1 || val2 !== 4'd4) begin fails++; $display("FAIL done_ignores_stop got done=%b val2=%0d want 1/4", done, val2); end
  endtask

  task automatic test_stop();
    pulse_start(2'b01, 4'd10);
    step();
    step();
    stop = 1'b1;
    #1;
    tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL stop_gnt got %b want 00", gnt); end
    step();
    stop = 1'b0;
    step();
    tests++; if (busy !== 1'b0 || done !== 1'b0 || val1 !== 4'd2) begin fails++; $display("FAIL stop_idle got busy=%b done=%b val1=%0d want 0/0/2", busy, done, val1); end
    tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL stop_idle_gnt got %b want 00", gnt); end
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    req = 2'b00;
    #1;
    tests++; if (busy !== 1'b1 || val1 !== 4'd0 || val2 !== 4'd0) begin fails++; $display("FAIL start_stop_together got busy=%b %0d/%0d want 1/0/0", busy, val1, val2); end
  endtask

  task automatic test_wrap();
    pulse_start(2'b01, 4'd0);
    for (int i = 0; i < 15; i++) step();
    tests++; if (val1 !== 4'd15 || done !== 1'b0) begin fails++; $display("FAIL wrap_at_max got val1=%0d done=%b want 15/0", val1, done); end
    step();
`ifdef COUNTER_SATURATE_EN
    tests++; if (val1 !== 4'd15 || done !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL sat_hold got val1=%0d done=%b busy=%b want 15/0/1", val1, done, busy); end
    step();
    tests++; if (val1 !== 4'd15 || done !== 1'b0) begin fails++; $display("FAIL sat_hold2 got val1=%0d done=%b want 15/0", val1, done); end
`else
    tests++; if (val1 !== 4'd0 || done !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL wrap_done got val1=%0d done=%b busy=%b want 0/1/0", val1, done, busy); end
    step();
    tests++; if (val1 !== 4'd0 || gnt !== 2'b00) begin fails++; $display("FAIL wrap_hold got val1=%0d gnt=%b want 0/00", val1, gnt); end
`endif
  endtask

  task automatic test_async_reset();
    pulse_start(2'b01, 4'd10);
    for (int i = 0; i < 5; i++) step();
    tests++; if (val1 !== 4'd5) begin fails++; $display("FAIL async_pre got val1=%0d want 5", val1); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (val1 !== 4'd0 || q !== 4'd0 || busy !== 1'b0 || gnt !== 2'b00) begin fails++; $display("FAIL async_reset got val1=%0d q=%0d busy=%b gnt=%b want 0/0/0/00", val1, q, busy, gnt); end
    step();
    rst_n = 1'b1;
    step();
    tests++; if (val1 !== 4'd0 || busy !== 1'b0 || gnt !== 2'b00) begin fails++; $display("FAIL async_after got val1=%0d busy=%b gnt=%b want 0/0/00", val1, busy, gnt); end
  endtask

  initial begin
    test_reset();
    test_fair();
    test_restart();
    test_single();
    test_stop();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
